uart_program_loader: RTL

Boot-time loader that receives a program image over a UART RX line and writes it word by word into the instruction RAM. It feeds the instruction RAM's write port. It holds the CPU stalled via cpu_hold until the image is complete, replacing hierarchical preloading of the RAM in hardware builds. Contains an 8N1 UART receiver and a framing state machine.

---
 rtl/uart_program_loader_pkg.sv | 21 ++
 rtl/uart_program_loader_rx.sv | 83 ++++++++
 rtl/uart_program_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader:
// loader FSM encoding and baud divisor helpers.
package uart_program_loader_pkg;

  localparam logic [2:0] HDR_HI = 3'd0;
  localparam logic [2:0] HDR_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int BIT_DIV  = 25000000 / 115200;
  localparam int HALF_DIV = BIT_DIV / 2;

  function automatic int bit_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit
// sampling, one-cycle byte_valid / framing_error pulses.
module uart_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_error
);
  import uart_program_loader_pkg::*;

  localparam int DIV  = bit_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_BITS  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          half_end;

  assign rx_s     = sync[1];
  assign bit_end  = (cnt == CW'(DIV - 1));
  assign half_end = (cnt == CW'(HALF - 1));
  assign data     = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync          <= 2'b11;
      rx_prev       <= 1'b1;
      st            <= RX_IDLE;
      cnt           <= '0;
      nbit          <= '0;
      shreg         <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync          <= {sync[0], rx};
      rx_prev       <= rx_s;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      cnt           <= cnt + CW'(1);
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) st <= RX_START;
        end
        // a start bit that is high again at mid-bit was a glitch
        RX_START: if (half_end) begin
          cnt  <= '0;
          nbit <= '0;
          st   <= rx_s ? RX_IDLE : RX_BITS;
        end
        RX_BITS: if (bit_end) begin
          cnt   <= '0;
          shreg <= {rx_s, shreg[7:1]};
          nbit  <= nbit + 3'd1;
          if (nbit == 3'd7) st <= RX_STOP;
        end
        RX_STOP: if (bit_end) begin
          st            <= RX_IDLE;
          byte_valid    <= rx_s;
          framing_error <= !rx_s;
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: frames a UART byte stream into words
// and writes them to instruction RAM, holding the CPU.
module uart_program_loader #(
  parameter int CLK_FREQ       = 25000000,
  parameter int BAUD           = 115200,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic                  clk_25mhz,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  import uart_program_loader_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  logic [7:0]            rx_data;
  logic                  byte_valid;
  logic                  framing_error;
  logic [2:0]            state;
  logic [7:0]            count_hi;
  logic [15:0]           count;
  logic [1:0]            byte_idx;
  logic [DATA_WIDTH-9:0] word;
  logic [TW-1:0]         tmo;
  logic [15:0]           hdr;
  logic                  hdr_bad;
  logic                  tmo_run;
  logic                  tmo_hit;
  logic [ADDR_WIDTH:0]   wl_next;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clk          (clk_25mhz),
    .rst          (reset),
    .rx           (rx),
    .data         (rx_data),
    .byte_valid   (byte_valid),
    .framing_error(framing_error)
  );

  assign hdr     = {count_hi, rx_data};
  assign hdr_bad = (hdr == 16'd0) || ({1'b0, hdr} > MAX_WORDS);
  assign tmo_run = (state == HDR_LO) || (state == DATA);
  assign tmo_hit = tmo_run && (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign wl_next = words_loaded + (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_write_data   <= '0;
      cpu_hold         <= 1'b1;
      done             <= 1'b0;
      error            <= 1'b0;
      words_loaded     <= '0;
      state            <= HDR_HI;
      count_hi         <= '0;
      count            <= '0;
      byte_idx         <= '0;
      word             <= '0;
      tmo              <= '0;
    end else begin
      ram_write_enable <= 1'b0;
      tmo <= (tmo_run && !byte_valid) ? tmo + TW'(1) : '0;
      // a loaded image survives line noise while the CPU runs
      if (framing_error) begin
        error <= 1'b1;
        if (state != DONE) state <= HDR_HI;
      end else if (tmo_hit && !byte_valid) begin
        error <= 1'b1;
        state <= HDR_HI;
      end else begin
        case (state)
          HDR_HI: if (byte_valid) begin
            count_hi <= rx_data;
            state    <= HDR_LO;
          end
          HDR_LO: if (byte_valid) begin
            if (hdr_bad) begin
              error <= 1'b1;
              state <= HDR_HI;
            end else begin
              count        <= hdr;
              words_loaded <= '0;
              done         <= 1'b0;
              error        <= 1'b0;
              byte_idx     <= '0;
              state        <= DATA;
            end
          end
          DATA: if (byte_valid) begin
            word     <= {word[DATA_WIDTH-17:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state            <= WRITE;
              ram_write_enable <= 1'b1;
              ram_address      <= words_loaded[ADDR_WIDTH-1:0];
              ram_write_data   <= {word, rx_data};
            end
          end
          WRITE: begin
            words_loaded <= wl_next;
            if (16'(wl_next) == count) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DONE: if (byte_valid) begin
            count_hi <= rx_data;
            state    <= HDR_LO;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
          end
          default: state <= HDR_HI;
        endcase
      end
    end
  end

endmodule
